// File: rtl/fb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_pkg : shared framebuffer geometry for the packer, scan-out and sw headers
// Rev 1.0
// ============================================================================
package fb_pkg;

  localparam int FB_WORDS        = 9600;
  localparam int FB_STRIDE       = 20;
  localparam int FB_PIX_PER_WORD = 32;
  localparam int FB_ADDR_W       = 15;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

endpackage
`default_nettype wire

// File: rtl/fb_out_slot.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_out_slot : single-entry write register held stable until granted
// Rev 1.0
// ============================================================================
module fb_out_slot
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [31:0]       load_data,
  input  logic              grant,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       writedata
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_address;
  logic [31:0]       r_writedata;

  // Load has priority: the caller only loads when the slot is empty or granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
    end else if (load) begin
      r_valid     <= 1'b1;
      r_address   <= load_address;
      r_writedata <= load_data;
    end else if (r_valid && grant) begin
      r_valid     <= 1'b0;
    end
  end

  assign valid     = r_valid;
  assign address   = r_address;
  assign writedata = r_writedata;

endmodule
`default_nettype wire

// File: rtl/fb_pixel_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_pixel_packer : packs a 1-bpp raster stream into 32-bit framebuffer writes
// Rev 1.0
// ============================================================================
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_data,
  input  logic              pix_sof,
  input  logic              flush,
  output logic              fb_write,
  input  logic              fb_grant,
  output logic [ADDR_W-1:0] fb_address,
  output logic [31:0]       fb_writedata,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_WORDS - 1);

  logic [31:0]       r_acc;
  logic [4:0]        r_fill;
  logic [ADDR_W-1:0] r_word_ptr;
  logic              r_flush_pending;
  logic              r_frame_done;

  logic              w_out_valid;
  logic              w_slot_free;
  logic              w_xfer;
  logic [31:0]       w_acc_ins;
  logic [5:0]        w_count;
  logic [ADDR_W-1:0] w_ptr_base;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              w_full;
  logic              w_flush_req;
  logic              w_flush_go;
  logic              w_load;

  assign pix_ready   = !r_flush_pending && !(r_fill == 5'd31 && w_out_valid && !fb_grant);
  assign w_slot_free = !w_out_valid || fb_grant;
  assign w_xfer      = pix_valid && pix_ready;

  // Pixel insertion is resolved first; flush then acts on the post-insert state.
  always_comb begin
    w_acc_ins  = r_acc;
    w_count    = {1'b0, r_fill};
    w_ptr_base = r_word_ptr;
    if (w_xfer) begin
      if (pix_sof) begin
        w_acc_ins  = {31'b0, pix_data};
        w_count    = 6'd1;
        w_ptr_base = '0;
      end else begin
        w_acc_ins  = r_acc | (32'(pix_data) << r_fill);
        w_count    = {1'b0, r_fill} + 6'd1;
      end
    end
    w_full      = (w_count == 6'(FB_PIX_PER_WORD));
    w_flush_req = flush || r_flush_pending;
    w_flush_go  = w_flush_req && !w_full && (w_count != 6'd0) && w_slot_free;
    w_load      = w_full || w_flush_go;
    w_ptr_next  = (w_ptr_base == c_last_addr) ? '0 : w_ptr_base + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc           <= '0;
      r_fill          <= '0;
      r_word_ptr      <= '0;
      r_flush_pending <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_frame_done <= w_out_valid && fb_grant && (fb_address == c_last_addr);
      if (w_load) begin
        r_acc           <= '0;
        r_fill          <= '0;
        r_word_ptr      <= w_ptr_next;
        r_flush_pending <= 1'b0;
      end else begin
        r_acc           <= w_acc_ins;
        r_fill          <= w_count[4:0];
        r_word_ptr      <= w_ptr_base;
        r_flush_pending <= w_flush_req && (w_count != 6'd0);
      end
    end
  end

  fb_out_slot #(
    .ADDR_W (ADDR_W)
  ) u_out_slot (
    .clk          (clk),
    .reset        (reset),
    .load         (w_load),
    .load_address (w_ptr_base),
    .load_data    (w_acc_ins),
    .grant        (fb_grant),
    .valid        (w_out_valid),
    .address      (fb_address),
    .writedata    (fb_writedata)
  );

  assign fb_write   = w_out_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_fill != 5'd0) || w_out_valid || r_flush_pending;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_fb_pixel_packer : directed scoreboard bench for fb_pixel_packer
// Rev 1.0
// ============================================================================
module tb_fb_pixel_packer;

  localparam int TB_WORDS = 40;
  localparam int ADDR_W   = 15;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(TB_WORDS - 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic              pix_data = 1'b0;
  logic              pix_sof = 1'b0;
  logic              flush = 1'b0;
  logic              fb_write;
  logic              fb_grant = 1'b0;
  logic [ADDR_W-1:0] fb_address;
  logic [31:0]       fb_writedata;
  logic              frame_done;
  logic              busy;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  fd_count = 0;
  int  stalls = 0;
  bit  fd_expect = 1'b0;

  fb_pixel_packer #(
    .FB_WORDS (TB_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .flush        (flush),
    .fb_write     (fb_write),
    .fb_grant     (fb_grant),
    .fb_address   (fb_address),
    .fb_writedata (fb_writedata),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every granted write.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      fd_expect = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_expect);
      if (frame_done) fd_count++;
      fd_expect = fb_write && fb_grant && (fb_address == c_last);
      if (fb_write && fb_grant) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed=%0h:%0h expected=none", fb_address, fb_writedata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", fb_address, e.addr);
          chk("wr_data", fb_writedata, e.data);
        end
      end
    end
  end

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic d, input logic s, input logic f = 1'b0);
    int n;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    flush     = f;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    stalls += n;
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) send(w[i], 1'b0);
  endtask

  task automatic send_n(input int n, input logic d);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset values while reset is held
    #25;
    chk("rst_pix_ready", pix_ready, 1'b1);
    chk("rst_fb_write", fb_write, 1'b0);
    chk("rst_fb_address", fb_address, '0);
    chk("rst_fb_writedata", fb_writedata, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    do_reset();

    // Alternating 1,0 with grant high
    fb_grant = 1'b1;
    push(0, 32'h5555_5555);
    stalls = 0;
    for (int i = 0; i < 32; i++) send(i % 2 == 0, 1'b0);
    chk("alt_stalls", 64'(stalls), 64'd0);
    drain("alt_drain");

    // Backpressure: grant low, pix_ready drops at fill 31
    do_reset();
    fb_grant = 1'b0;
    push(0, 32'hFFFF_FFFF);
    push(1, 32'hFFFF_FFFF);
    send_n(63, 1'b1);
    @(negedge clk);
    chk("bp_ready_low", pix_ready, 1'b0);
    chk("bp_write", fb_write, 1'b1);
    chk("bp_busy", busy, 1'b1);
    repeat (4) @(negedge clk);
    chk("bp_addr_hold", fb_address, '0);
    chk("bp_data_hold", fb_writedata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 fb_grant = 1'b1;
    send(1'b1, 1'b0);
    drain("bp_drain");

    // Flush of a partial word, then a full zero word
    do_reset();
    fb_grant = 1'b1;
    push(0, 32'h0000_001F);
    send_n(5, 1'b1);
    pulse_flush();
    chk("flush_latency", fb_write, 1'b1);
    push(1, 32'h0000_0000);
    send_n(32, 1'b0);
    drain("flush_drain");

    // sof discards the partial accumulator
    do_reset();
    push(0, 32'h0000_0001);
    send_n(10, 1'b1);
    send(1'b1, 1'b1);
    send_n(31, 1'b0);
    drain("sof_drain");
    chk("sof_idle_busy", busy, 1'b0);

    // Pixel completing a word with a simultaneous flush: no extra word
    do_reset();
    push(0, 32'hFFFF_FFFF);
    send_n(31, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    drain("pixflush_drain");
    pulse_flush();
    repeat (2) @(posedge clk);
    #1;
    chk("flush_empty_noop", fb_write, 1'b0);

    // sof together with flush
    push(0, 32'h0000_0000);
    send_n(3, 1'b1);
    send(1'b0, 1'b1, 1'b1);
    drain("sofflush_drain");
    push(1, 32'hF0F0_F0F0);
    send_word(32'hF0F0_F0F0);
    drain("sofflush_next");

    // Flush pending while the output register is blocked
    do_reset();
    fb_grant = 1'b0;
    push(0, 32'hFFFF_FFFF);
    push(1, 32'h0000_0007);
    send_n(35, 1'b1);
    pulse_flush();
    @(negedge clk);
    chk("pend_ready_low", pix_ready, 1'b0);
    chk("pend_busy", busy, 1'b1);
    @(posedge clk);
    #1 fb_grant = 1'b1;
    drain("pend_drain");

    // Full frame, wrap, frame_done
    do_reset();
    fb_grant = 1'b1;
    fd_count = 0;
    for (int w = 0; w < TB_WORDS; w++) begin
      logic [31:0] v;
      v = {16'(w) ^ 16'hA5C3, ~16'(w)};
      push(w, v);
      send_word(v);
    end
    drain("frame_drain");
    chk("frame_done_count", 64'(fd_count), 64'd1);
    push(0, 32'h1234_5678);
    send_word(32'h1234_5678);
    drain("wrap_drain");
    chk("frame_done_once", 64'(fd_count), 64'd1);

    // Reset with a pending word and fill 17
    do_reset();
    fb_grant = 1'b0;
    send_n(49, 1'b1);
    @(negedge clk);
    chk("mid_pending", fb_write, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_write", fb_write, 1'b0);
    chk("mid_rst_ready", pix_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", fb_address, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fb_grant = 1'b1;
    push(0, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D);
    drain("mid_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_pixel_packer.md
# fb_pixel_packer

Writer-side counterpart of the VGA scan-out framebuffer: accepts a 1-bit-per-pixel raster stream and packs it into 32-bit words. It issues word writes on the framebuffer write port (address, data, write) through an external arbiter grant. The packer is the hardware path for filling the 640×480 monochrome frame without CPU word assembly.

## Interface
Parameters:
- FB_WORDS, 9600, words per frame (640×480/32); the address wraps after FB_WORDS-1
- ADDR_W, 15, framebuffer word-address width

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- pix_valid  in  1  pixel present
- pix_ready  out  1  packer accepts the pixel this cycle
- pix_data  in  1  pixel value (1 = white)
- pix_sof  in  1  qualifies the pixel as pixel 0 of a frame
- flush  in  1  single-cycle pulse: emit the partial word, zero-padded
- fb_write  out  1  write request to the framebuffer
- fb_grant  in  1  arbiter accepts the request this cycle
- fb_address  out  ADDR_W  word address
- fb_writedata  out  32  packed word
- frame_done  out  1  one-cycle pulse when word FB_WORDS-1 is accepted
- busy  out  1  accumulator non-empty, output word pending, or flush pending

## Operation
- Pixel transfer occurs when pix_valid && pix_ready.
- Bit order: the first pixel of a word goes to bit 0, the 32nd to bit 31. Pixel p of a frame maps to address p>>5, bit p[4:0]. Row stride is 20 words.
- Accumulator: a 32-bit shift/insert register plus a 5-bit fill count. When the 32nd pixel is accepted, the word moves to the output register at address word_ptr, and word_ptr increments. word_ptr wraps FB_WORDS-1 → 0.
- Output register: a single entry. It holds fb_write, fb_address and fb_writedata stable until fb_grant is sampled high.
- pix_ready = !flush_pending && !(fill==31 && out_valid && !fb_grant). The output register frees in the same cycle it is granted, so the next word can load that edge.
- pix_sof on a transferred pixel: the partial accumulator is discarded and never written. word_ptr becomes 0, and the pixel lands at bit 0. A complete word already in the output register is still written at its original address.
- flush:
  - With fill>0, the unfilled bits are zeroed and the word is queued at word_ptr. word_ptr then increments and fill becomes 0.
  - With fill==0, flush is a no-op.
  - If the output register is occupied and not granted, flush_pending is set. It executes when the register frees, and pix_ready stays low until then.
- Simultaneous pixel and flush in one cycle: the pixel is inserted first, then the flush applies. If that pixel completes the word, only the normal word is emitted; there is no extra padded word.
- Simultaneous pix_sof and flush: the sof pixel goes to bit 0 of address 0, and the result is word 0x0000_0001 or 0x0000_0000 at address 0.
- frame_done pulses in the cycle after the grant of the write at address FB_WORDS-1, whether that word came from a full word or a flush.
- Reset mid-operation discards all state immediately. No partial write is issued.

## Timing
- Reset values: pix_ready=1, fb_write=0, fb_address=0, fb_writedata=0, frame_done=0, busy=0. word_ptr=0, fill=0.
- Latency: fb_write rises on the edge following acceptance of the 32nd pixel, or following the flush pulse.
- Throughput: 1 pixel/cycle sustained with fb_grant tied high, which gives 1 write per 32 cycles.
- Grant without fb_write is ignored.
- fb_address and fb_writedata must not change while fb_write=1 and fb_grant=0.

## Structure
- Package fb_pkg holds FB_WORDS, FB_STRIDE=20, FB_PIX_PER_WORD=32, FB_ADDR_W=15, and the word-address typedef. The scan-out peripheral and software header generation share this package.
- One sub-module, fb_out_slot, implements the single-entry output register with the grant handshake.
- The accumulator, pointer and flush logic stay in the top level.

## Test plan
- Reset, then 32 pixels alternating 1,0 with grant high → one write, address 0, data 0x5555_5555; pix_ready never drops.
- 64 all-ones pixels with grant held low for 40 cycles → first word pending, pix_ready drops at fill 31. After grant, two writes: addr 0 then 1, both 0xFFFF_FFFF.
- 5 ones then a flush pulse → write addr 0, data 0x0000_001F. Then 32 zeros → write addr 1, data 0.
- 10 pixels, then a sof pixel =1 followed by 31 zeros → only one write: addr 0, data 0x0000_0001.
- Full frame of 307200 pixels → the last write is addr 9599, and frame_done pulses once in the cycle after its grant. The next pixel packs into address 0.
- Assert reset while a word is pending and fill=17 → fb_write drops immediately. After release, the next 32 pixels write address 0.
